// File: rtl/norm_shf_74_pkg.sv
// ---------------------------------------------------------------------------
// norm_shf_74_pkg
// Shared widths, the exponent floor, and the stage-1 shift clamp helper for
// the FMA post-add normalizer (norm_shf_74) and its leading-zero counter.
// ---------------------------------------------------------------------------
package norm_shf_74_pkg;

    localparam int SUM_W    = 74;
    localparam int FRAC_W   = 26;
    localparam int EXP_W    = 10;
    localparam int LZC_W    = 7;
    localparam int EXP_MIN  = 1;

    // Bits of the shifted sum that fall below the round bit.
    localparam int STICKY_W = SUM_W - FRAC_W;

    localparam logic signed [EXP_W-1:0] EXP_MIN_S = EXP_W'(EXP_MIN);
    localparam logic signed [EXP_W:0]   EXP_MIN_X = (EXP_W+1)'(EXP_MIN);

    typedef struct packed {
        logic [LZC_W-1:0] lzc;
        logic [LZC_W-1:0] shift;
        logic             tiny;
    } clamp_t;

    // Pick the left-shift amount so the result exponent never drops below
    // EXP_MIN. A zero sum always gets shift 0 / tiny 0.
    function automatic clamp_t calc_clamp(input logic [EXP_W-1:0] e,
                                          input logic [LZC_W-1:0] lzc,
                                          input logic             zero);
        clamp_t c;
        logic signed [EXP_W:0] headroom;
        headroom = $signed({e[EXP_W-1], e}) -
                   $signed({{(EXP_W+1-LZC_W){1'b0}}, lzc});
        c.lzc   = lzc;
        c.shift = '0;
        c.tiny  = 1'b0;
        if (!zero) begin
            if ($signed(e) < EXP_MIN_S) begin
                c.tiny = 1'b1;
            end else if (headroom < EXP_MIN_X) begin
                // e is in 1..lzc here, so e-1 fits the shift width.
                c.shift = LZC_W'(e - EXP_W'(EXP_MIN));
                c.tiny  = 1'b1;
            end else begin
                c.shift = lzc;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/norm_shf_74_lzc.sv
// ---------------------------------------------------------------------------
// lzc_74
// Combinational leading-zero counter for the 74-bit normalizer input.
//   sum      : value to scan, bit 73 is the MSB
//   lzc      : number of leading zeros, 0..74 (74 when sum is zero)
//   all_zero : sum is all-zero
// ---------------------------------------------------------------------------
module lzc_74
    import norm_shf_74_pkg::*;
(
    input  logic [SUM_W-1:0] sum,
    output logic [LZC_W-1:0] lzc,
    output logic             all_zero
);

    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        lzc = LZC_W'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (sum[i]) begin
                lzc = LZC_W'(SUM_W - 1 - i);
            end
        end
    end

    assign all_zero = ~|sum;

endmodule

// File: rtl/norm_shf_74.sv
// ---------------------------------------------------------------------------
// norm_shf_74
// Two-stage normalizer for the FMA sum magnitude.
//   Stage 1: leading-zero count and exponent-floor clamp of the shift.
//   Stage 2: 7-level log left shifter, exponent subtract, sticky OR.
// Global stall (out_valid & ~out_ready) freezes both stages.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid/ready: input handshake (in_ready = ~stall)
//   sum, sum_exp  : 74-bit magnitude, signed exponent of sum[73]
//   out_valid/ready: output handshake
//   norm_frac     : 24-bit fraction plus guard and round
//   norm_sticky   : OR of bits below round
//   norm_exp      : signed exponent of norm_frac[25]
//   norm_zero     : input sum was zero
//   norm_tiny     : shift limited by the exponent floor
//
// Build option: define NORM_STICKY_EN to generate norm_sticky; otherwise it
// is tied low and no sticky reduction is built.
// ---------------------------------------------------------------------------
module norm_shf_74
    import norm_shf_74_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  sum,
    input  logic [EXP_W-1:0]  sum_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] norm_frac,
    output logic              norm_sticky,
    output logic [EXP_W-1:0]  norm_exp,
    output logic              norm_zero,
    output logic              norm_tiny
);

    logic stall;
    logic accept;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // ---------------- stage 1 ----------------
    logic [LZC_W-1:0] lzc_c;
    logic             zero_c;
    clamp_t           clamp_c;

    lzc_74 u_lzc (
        .sum      (sum),
        .lzc      (lzc_c),
        .all_zero (zero_c)
    );

    assign clamp_c = calc_clamp(sum_exp, lzc_c, zero_c);

    logic             s1_valid;
    logic [SUM_W-1:0] s1_sum;
    logic [EXP_W-1:0] s1_exp;
    clamp_t           s1_clamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_exp   <= '0;
            s1_clamp <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_sum   <= sum;
                s1_exp   <= sum_exp;
                s1_clamp <= clamp_c;
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [SUM_W-1:0] lvl [LZC_W+1];

    assign lvl[0] = s1_sum;
    for (genvar k = 0; k < LZC_W; k++) begin : g_shf
        assign lvl[k+1] = s1_clamp.shift[k] ? (lvl[k] << (2**k)) : lvl[k];
    end

    logic [SUM_W-1:0]  shifted;
    logic [FRAC_W-1:0] frac_c;
    logic [EXP_W-1:0]  exp_c;
    logic              s1_zero;

    assign shifted = lvl[LZC_W];
    assign frac_c  = shifted[SUM_W-1 -: FRAC_W];
    // Only a zero sum produces the out-of-range count.
    assign s1_zero = (s1_clamp.lzc == LZC_W'(SUM_W));
    assign exp_c   = s1_zero ? '0
                   : s1_exp - {{(EXP_W-LZC_W){1'b0}}, s1_clamp.shift};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            norm_frac <= '0;
            norm_exp  <= '0;
            norm_zero <= 1'b0;
            norm_tiny <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                norm_frac <= frac_c;
                norm_exp  <= exp_c;
                norm_zero <= s1_zero;
                norm_tiny <= s1_clamp.tiny;
            end
        end
    end

`ifdef NORM_STICKY_EN
    logic sticky_c;
    assign sticky_c = |shifted[STICKY_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            norm_sticky <= 1'b0;
        end else if (!stall && s1_valid) begin
            norm_sticky <= sticky_c;
        end
    end
`else
    logic [STICKY_W-1:0] sticky_bits_unused;
    assign sticky_bits_unused = shifted[STICKY_W-1:0];
    assign norm_sticky        = 1'b0;
`endif

endmodule
